// File: rtl/mdu_core.sv
// Multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU over a fixed
// busy latency, executes MTHI/MTLO and serves MFHI/MFLO reads combinationally.
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic          accept;
  logic [63:0]   prod_s, prod_u;
  logic          a_neg, b_neg, b_zero;
  logic [31:0]   a_mag, b_mag, divisor_s, divisor_u;
  logic [31:0]   uq_s, ur_s, quo_s, rem_s, quo_u, rem_u;

  // Low 64 bits of a sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divide-by-zero uses a dummy divisor of 1; the result is never written back.
  assign b_zero    = (b == 32'd0);
  assign a_neg     = a[31];
  assign b_neg     = b[31];
  assign a_mag     = a_neg ? (32'd0 - a) : a;
  assign b_mag     = b_neg ? (32'd0 - b) : b;
  assign divisor_s = b_zero ? 32'd1 : b_mag;
  assign divisor_u = b_zero ? 32'd1 : b;
  assign uq_s      = a_mag / divisor_s;
  assign ur_s      = a_mag % divisor_s;
  assign quo_s     = (a_neg ^ b_neg) ? (32'd0 - uq_s) : uq_s;
  assign rem_s     = a_neg ? (32'd0 - ur_s) : ur_s;
  assign quo_u     = a / divisor_u;
  assign rem_u     = a % divisor_u;

  assign accept = start & ~flush & (state_q == S_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = S_BUSY;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = S_BUSY;
            end
            OP_DIV: begin
              pend_hi_d = rem_s;
              pend_lo_d = quo_s;
              pend_wr_d = ~b_zero;
              cnt_d     = CW'(DIV_CYCLES);
              state_d   = S_BUSY;
            end
            OP_DIVU: begin
              pend_hi_d = rem_u;
              pend_lo_d = quo_u;
              pend_wr_d = ~b_zero;
              cnt_d     = CW'(DIV_CYCLES);
              state_d   = S_BUSY;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_wr_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy  = (state_q == S_BUSY);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_core.sv
// Scoreboard bench for mdu_core: arithmetic results are queued at issue and
// checked by a monitor when busy falls; MTHI/MTLO/reset are checked inline.
module tb_mdu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        flush = 1'b0;
  logic        rd_hi = 1'b0;
  logic        busy;
  logic [31:0] rdata, hi, lo;

  mdu_core #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .rd_hi(rd_hi), .busy(busy), .rdata(rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   allow_viol = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks HI/LO in the cycle busy falls.
  int  bcnt = 0;
  bit  prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      prev_busy = 1'b0;
      bcnt = 0;
    end else begin
      if (start && busy && !allow_viol) begin
        n_fail++;
        $display("FAIL protocol: start asserted while busy");
      end
      if (busy) bcnt++;
      else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_completion: busy fell with empty scoreboard");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          chk({e.name, "_lat"}, 32'(bcnt), 32'(e.lat));
        end
        bcnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic fl);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = av; b = bv; flush = fl;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; flush = 1'b0;
  endtask

  task automatic push(input string n, input logic [31:0] h, input logic [31:0] l, input int lat);
    exp_t e;
    e.name = n; e.hi = h; e.lo = l; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: operation did not complete within 40 cycles", n);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    wait_idle("mult");

    push("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle("multu");

    push("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    @(negedge clk);
    rd_hi = 1'b0; #1;
    chk("rdata_old_lo_during_busy", rdata, 32'hFFFF_FFFE);
    wait_idle("div");

    push("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'd4, 32'd7, 32'd0, 1'b0);
    wait_idle("divu_by0");

    push("div_ovf", 32'h0000_0000, 32'h8000_0000, 10);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle("div_ovf");

    push("divu", 32'd2, 32'd14, 10);
    issue(3'd4, 32'd100, 32'd7, 1'b0);
    wait_idle("divu");

    push("div_negb", 32'd1, 32'hFFFF_FFFD, 10);
    issue(3'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_idle("div_negb");

    issue(3'd5, 32'h1234_5678, 32'd0, 1'b1);
    #1;
    chk("mthi_flushed", hi, 32'd1);
    issue(3'd5, 32'h1234_5678, 32'd0, 1'b0);
    #1;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", 32'(busy), 32'd0);
    rd_hi = 1'b1; #1;
    chk("rdata_hi", rdata, 32'h1234_5678);
    issue(3'd6, 32'hCAFE_BABE, 32'd0, 1'b0);
    rd_hi = 1'b0; #1;
    chk("rdata_lo", rdata, 32'hCAFE_BABE);

    push("flush_in_busy", 32'd0, 32'd12, 5);
    issue(3'd2, 32'd3, 32'd4, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_idle("flush_in_busy");

    push("viol", 32'd0, 32'd30, 5);
    issue(3'd1, 32'd5, 32'd6, 1'b0);
    allow_viol = 1'b1;
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    allow_viol = 1'b0;
    wait_idle("viol");
    repeat (3) @(posedge clk);
    #1 chk("viol_lo_kept", lo, 32'd30);

    push("div_abort", 32'd2, 32'd14, 10);
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_wb_busy", 32'(busy), 32'd0);
      chk("abort_no_wb_hilo", hi | lo, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
